// File: rtl/alu_mul_pkg.sv
// alu_mul_pkg: shared widths, FSM state type and per-step partial-product shift for the iterative multiplier
package alu_mul_pkg;
  localparam int NIB_W = 4;
  localparam int OP_W = 8;
  localparam int RES_W = 16;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic logic [3:0] step_shift(input logic [1:0] s);
    return s == 2'd0 ? 4'd0 : s == 2'd3 ? 4'd8 : 4'd4;
  endfunction
endpackage

// File: rtl/mul_8x8_iter_if.sv
// mul_8x8_iter_if: operand (in_valid/in_ready/a/b) and result (out_valid/out_ready/product) handshakes; master drives operands, slave is the multiplier
interface mul_8x8_iter_if;
  import alu_mul_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [OP_W-1:0] a;
  logic [OP_W-1:0] b;
  logic out_valid;
  logic out_ready;
  logic [RES_W-1:0] product;
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, product);
  modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, product);
endinterface

// File: rtl/mul_4x4_exact.sv
// mul_4x4_exact: combinational 4x4 unsigned multiply, x_i/y_i nibbles in, 8-bit p_o out
module mul_4x4_exact
  import alu_mul_pkg::*;
(
  input  logic [NIB_W-1:0]   x_i,
  input  logic [NIB_W-1:0]   y_i,
  output logic [2*NIB_W-1:0] p_o
);
  assign p_o = {{NIB_W{1'b0}}, x_i} * {{NIB_W{1'b0}}, y_i};
endmodule

// File: rtl/mul_8x8_iter.sv
// mul_8x8_iter: 8x8 unsigned multiply over four nibble steps on one 4x4 core; clk, sync active-low rst_n, handshakes on bus (slave), LSB_DROP skips aL*bL
module mul_8x8_iter
  import alu_mul_pkg::*;
#(
  parameter bit LSB_DROP = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  mul_8x8_iter_if.slave bus
);
  state_t state_q, state_d;
  logic [1:0] step_q, step_d;
  logic [OP_W-1:0] a_q, a_d, b_q, b_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [NIB_W-1:0] x, y;
  logic [2*NIB_W-1:0] pp;
  logic [RES_W-1:0] pp_ext, term;
  assign x = step_q[0] ? a_q[OP_W-1:NIB_W] : a_q[NIB_W-1:0];
  assign y = step_q[1] ? b_q[OP_W-1:NIB_W] : b_q[NIB_W-1:0];
  mul_4x4_exact u_core (.x_i(x), .y_i(y), .p_o(pp));
  assign pp_ext = {{(RES_W-2*NIB_W){1'b0}}, pp};
  assign term = (LSB_DROP && step_q == 2'd0) ? '0 : pp_ext << step_shift(step_q);
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        a_d = bus.a;
        b_d = bus.b;
        acc_d = '0;
        step_d = '0;
        state_d = CALC;
      end
      CALC: begin
        acc_d = acc_q + term;
        step_d = step_q + 2'd1;
        state_d = step_q == 2'd3 ? DONE : CALC;
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q <= '0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
    end
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.product = acc_q;
endmodule

// File: tb/tb_mul_8x8_iter.sv
// tb_mul_8x8_iter: exact and approximate multipliers in lockstep, scoreboard queues checked by a negedge monitor
module tb_mul_8x8_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int acc_cyc = 0;
  logic ov0 = 1'b0;
  logic ov1 = 1'b0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  mul_8x8_iter_if bus0 ();
  mul_8x8_iter_if bus1 ();
  assign bus1.in_valid = bus0.in_valid;
  assign bus1.a = bus0.a;
  assign bus1.b = bus0.b;
  assign bus1.out_ready = bus0.out_ready;
  mul_8x8_iter #(.LSB_DROP(1'b0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mul_8x8_iter #(.LSB_DROP(1'b1)) dut_ap (.clk(clk), .rst_n(rst_n), .bus(bus1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      chk("handshake_exclusive", {31'd0, bus0.in_ready & bus0.out_valid}, 32'd0);
      if (bus0.out_valid && !ov0) chk("latency_exact", cyc - acc_cyc, 4);
      if (bus1.out_valid && !ov1) chk("latency_approx", cyc - acc_cyc, 4);
      if (bus0.out_valid && bus0.out_ready) begin
        if (q0.size() == 0) chk("unexpected_exact", 32'd1, 32'd0);
        else chk("product_exact", {16'd0, bus0.product}, {16'd0, q0.pop_front()});
      end
      if (bus1.out_valid && bus1.out_ready) begin
        if (q1.size() == 0) chk("unexpected_approx", 32'd1, 32'd0);
        else chk("product_approx", {16'd0, bus1.product}, {16'd0, q1.pop_front()});
      end
    end
    ov0 = bus0.out_valid;
    ov1 = bus1.out_valid;
  end
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] ex, input logic [15:0] ap);
    int n = 0;
    bus0.in_valid = 1'b1;
    bus0.a = av;
    bus0.b = bv;
    while (!bus0.in_ready && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) chk("accept_timeout", 32'd1, 32'd0);
    q0.push_back(ex);
    q1.push_back(ap);
    acc_cyc = cyc + 1;
    tick();
    bus0.in_valid = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) chk("result_timeout", 32'd1, 32'd0);
    tick();
  endtask
  task automatic wait_valid();
    int n = 0;
    while (!bus0.out_valid && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) chk("valid_timeout", 32'd1, 32'd0);
  endtask
  initial begin
    bus0.in_valid = 1'b0;
    bus0.a = '0;
    bus0.b = '0;
    bus0.out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    chk("reset_in_ready", {31'd0, bus0.in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("reset_product", {16'd0, bus0.product}, 32'h0000);
    send(8'h12, 8'h34, 16'h03A8, 16'h03A0);
    wait_valid();
    tick();
    chk("in_ready_after_hs", {31'd0, bus0.in_ready}, 32'd1);
    chk("out_valid_after_hs", {31'd0, bus0.out_valid}, 32'd0);
    wait_done();
    send(8'hFF, 8'hFF, 16'hFE01, 16'hFD20);
    wait_done();
    send(8'h00, 8'hAB, 16'h0000, 16'h0000);
    wait_done();
    send(8'h80, 8'h02, 16'h0100, 16'h0100);
    wait_done();
    send(8'h0F, 8'h0F, 16'h00E1, 16'h0000);
    wait_done();
    bus0.out_ready = 1'b0;
    send(8'hA5, 8'h5A, 16'h3A02, 16'h39D0);
    wait_valid();
    bus0.in_valid = 1'b1;
    bus0.a = 8'h07;
    bus0.b = 8'h09;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_product", {16'd0, bus0.product}, 32'h3A02);
      chk("stall_no_accept", {31'd0, bus0.in_ready}, 32'd0);
    end
    bus0.out_ready = 1'b1;
    q0.push_back(16'h003F);
    q1.push_back(16'h0000);
    acc_cyc = cyc + 2;
    tick();
    chk("stall_release_ready", {31'd0, bus0.in_ready}, 32'd1);
    tick();
    bus0.in_valid = 1'b0;
    chk("stall_new_accept", {31'd0, bus0.in_ready}, 32'd0);
    wait_done();
    send(8'h12, 8'h34, 16'h03A8, 16'h03A0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    q0.delete();
    q1.delete();
    rst_n = 1'b1;
    chk("midreset_in_ready", {31'd0, bus0.in_ready}, 32'd1);
    chk("midreset_out_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("midreset_product", {16'd0, bus0.product}, 32'h0000);
    send(8'h03, 8'h05, 16'h000F, 16'h0000);
    wait_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
